// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// conv_line_buffer : raster pixel stream -> five vertically aligned pixels
// Rev 1.0
// ============================================================================
module conv_line_buffer #(
  parameter int DW    = 32,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d_in,
  input  logic          in_valid,
  output logic [DW-1:0] d_out1,
  output logic [DW-1:0] d_out2,
  output logic [DW-1:0] d_out3,
  output logic [DW-1:0] d_out4,
  output logic [DW-1:0] d_out5,
  output logic          out_valid,
  output logic          out_sol,
  output logic          frame_done
);

  localparam int c_CW = $clog2(IMG_W);
  localparam int c_RW = $clog2(IMG_H);
  localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'(IMG_W - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST  = c_RW'(IMG_H - 1);
  localparam logic [c_RW-1:0] c_ROW_FIRST = c_RW'(4);

  logic [c_CW-1:0] r_col;
  logic [c_RW-1:0] r_row;
  logic [DW-1:0]   r_lb [4][IMG_W];

  logic w_col_last;
  logic w_row_last;
  logic w_row_emits;

  assign w_col_last  = (r_col == c_COL_LAST);
  assign w_row_last  = (r_row == c_ROW_LAST);
  assign w_row_emits = (r_row >= c_ROW_FIRST);

  // Raster position of the pixel being accepted; wraps to (0,0) after the frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Column-wise shift of the four stored rows; contents need no reset because
  // rows 0..3 of every frame refill them before any output is flagged valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int k = 0; k < 3; k++) begin
        r_lb[k][r_col] <= r_lb[k+1][r_col];
      end
      r_lb[3][r_col] <= d_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out1     <= '0;
      d_out2     <= '0;
      d_out3     <= '0;
      d_out4     <= '0;
      d_out5     <= '0;
      out_valid  <= 1'b0;
      out_sol    <= 1'b0;
      frame_done <= 1'b0;
    end else if (in_valid) begin
      d_out1     <= r_lb[0][r_col];
      d_out2     <= r_lb[1][r_col];
      d_out3     <= r_lb[2][r_col];
      d_out4     <= r_lb[3][r_col];
      d_out5     <= d_in;
      out_valid  <= w_row_emits;
      out_sol    <= w_row_emits && (r_col == '0);
      frame_done <= w_row_last && w_col_last;
    end else begin
      out_valid  <= 1'b0;
      out_sol    <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_line_buffer.sv
`default_nettype none
// ============================================================================
// tb_conv_line_buffer : scoreboard bench for conv_line_buffer (8x8 frames)
// Rev 1.0
// ============================================================================
module tb_conv_line_buffer;

  localparam int c_DW = 32;
  localparam int c_W  = 8;
  localparam int c_H  = 8;

  logic            clk;
  logic            rst_n;
  logic [c_DW-1:0] d_in;
  logic            in_valid;
  logic [c_DW-1:0] d_out1, d_out2, d_out3, d_out4, d_out5;
  logic            out_valid, out_sol, frame_done;

  conv_line_buffer #(.DW(c_DW), .IMG_W(c_W), .IMG_H(c_H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .in_valid   (in_valid),
    .d_out1     (d_out1),
    .d_out2     (d_out2),
    .d_out3     (d_out3),
    .d_out4     (d_out4),
    .d_out5     (d_out5),
    .out_valid  (out_valid),
    .out_sol    (out_sol),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ov;
    logic        sol;
    logic        done;
    logic        chk;   // d1..d4 predictable (previous rows belong to this frame)
    logic [31:0] d1, d2, d3, d4, d5;
  } exp_t;

  exp_t sb[$];
  exp_t hold;
  int   n_chk;
  int   n_err;
  int   n_ov;
  int   n_done;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One input cycle: drive at the falling edge and queue what the DUT must show after the next rising edge.
  task automatic push_cycle(input bit v, input int r, input int c, input logic [31:0] base);
    exp_t        e;
    logic [31:0] pix;
    @(negedge clk);
    pix      = base + 32'(r * 16 + c);
    in_valid = v;
    d_in     = v ? pix : $urandom;
    if (v) begin
      hold.d5 = pix;
      if (r >= 4) begin
        hold.d1  = base + 32'((r - 4) * 16 + c);
        hold.d2  = base + 32'((r - 3) * 16 + c);
        hold.d3  = base + 32'((r - 2) * 16 + c);
        hold.d4  = base + 32'((r - 1) * 16 + c);
        hold.chk = 1'b1;
      end else begin
        hold.chk = 1'b0;
      end
    end
    e      = hold;
    e.ov   = v && (r >= 4);
    e.sol  = v && (r >= 4) && (c == 0);
    e.done = v && (r == c_H - 1) && (c == c_W - 1);
    sb.push_back(e);
  endtask

  // mode 0: continuous, 1: gap after every pixel, 2: random gaps. Stops after raster index last_idx.
  task automatic send_frame(input logic [31:0] base, input int mode, input int last_idx);
    for (int r = 0; r < c_H; r++) begin
      for (int c = 0; c < c_W; c++) begin
        if (r * c_W + c <= last_idx) begin
          push_cycle(1'b1, r, c, base);
          if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0))
            push_cycle(1'b0, 0, 0, base);
        end
      end
    end
  endtask

  task automatic drain();
    push_cycle(1'b0, 0, 0, 32'd0);
    push_cycle(1'b0, 0, 0, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_counts(input string tag, input int ov_exp, input int done_exp);
    check_eq({tag, "_valid_cycles"}, 32'(n_ov), 32'(ov_exp));
    check_eq({tag, "_frame_done_pulses"}, 32'(n_done), 32'(done_exp));
    n_ov   = 0;
    n_done = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_d_out1"}, d_out1, 32'd0);
    check_eq({tag, "_d_out2"}, d_out2, 32'd0);
    check_eq({tag, "_d_out3"}, d_out3, 32'd0);
    check_eq({tag, "_d_out4"}, d_out4, 32'd0);
    check_eq({tag, "_d_out5"}, d_out5, 32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_sol"}, 32'(out_sol), 32'd0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_valid === 1'b1) n_ov++;
    if (frame_done === 1'b1) n_done++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("out_valid", 32'(out_valid), 32'(e.ov));
      check_eq("out_sol", 32'(out_sol), 32'(e.sol));
      check_eq("frame_done", 32'(frame_done), 32'(e.done));
      check_eq("d_out5", d_out5, e.d5);
      if (e.chk) begin
        check_eq("d_out1", d_out1, e.d1);
        check_eq("d_out2", d_out2, e.d2);
        check_eq("d_out3", d_out3, e.d3);
        check_eq("d_out4", d_out4, e.d4);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk    = 0;
    n_err    = 0;
    n_ov     = 0;
    n_done   = 0;
    hold     = '{ov: 1'b0, sol: 1'b0, done: 1'b0, chk: 1'b1,
                 d1: 32'd0, d2: 32'd0, d3: 32'd0, d4: 32'd0, d5: 32'd0};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    d_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous single frame.
    send_frame(32'h000, 0, c_W * c_H - 1);
    drain();
    check_counts("frame_cont", 32, 1);

    // Toggling in_valid, immediately followed by a second frame with offset values.
    send_frame(32'h000, 1, c_W * c_H - 1);
    send_frame(32'h100, 0, c_W * c_H - 1);
    drain();
    check_counts("frame_b2b", 64, 2);

    // Partial frame up to pixel (5,3), then an asynchronous reset in mid-cycle.
    send_frame(32'h200, 0, 5 * c_W + 3);
    drain();
    check_counts("frame_partial", 12, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    hold = '{ov: 1'b0, sol: 1'b0, done: 1'b0, chk: 1'b1,
             d1: 32'd0, d2: 32'd0, d3: 32'd0, d4: 32'd0, d5: 32'd0};
    @(negedge clk);
    rst_n = 1'b1;
    n_ov   = 0;
    n_done = 0;

    // Fresh frame after reset, with random gaps.
    send_frame(32'h300, 2, c_W * c_H - 1);
    drain();
    check_counts("frame_after_reset", 32, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
